// File: rtl/frame_seq_ctrl.sv
// Run controller for the frame/line pattern generator: gates gen_en, counts whole frames,
// ends runs only on a frame boundary and checks every frame's line/pixel geometry.
module frame_seq_ctrl #(
    parameter int HANG_NUM    = 32,
    parameter int LIE_NUM     = 32,
    parameter int ARM_TIMEOUT = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             err_clr,
    input  logic [CNT_W-1:0] frame_cfg,
    input  logic             fs,
    input  logic             hs,
    output logic             gen_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_done,
    output logic             line_err,
    output logic             pix_err,
    output logic             tmo_err
);
    localparam int GW     = 11;
    localparam int WAIT_W = $clog2(ARM_TIMEOUT + 1);

    localparam logic [GW-1:0]     G_MAX    = '1;
    localparam logic [GW-1:0]     HANG_V   = GW'(HANG_NUM);
    localparam logic [GW-1:0]     LIE_V    = GW'(LIE_NUM);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(ARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic              fs_d, hs_d;
    logic [GW-1:0]     line_cnt, line_cnt_nxt;
    logic [GW-1:0]     pix_cnt, pix_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  cfg, cfg_nxt, frames_nxt, frames_inc;
    logic              stop_pend, stop_pend_nxt;
    logic              line_err_nxt, pix_err_nxt, tmo_err_nxt;
    logic              fs_rise, fs_fall, hs_rise, hs_fall;
    logic [GW-1:0]     lines_seen;

    assign fs_rise = fs & ~fs_d;
    assign fs_fall = ~fs & fs_d;
    assign hs_rise = hs & ~hs_d;
    assign hs_fall = ~hs & hs_d;

    // A line ending on the same cycle as the frame must be included in the frame compare.
    assign lines_seen = (hs_fall && line_cnt != G_MAX) ? line_cnt + 1'b1 : line_cnt;
    assign frames_inc = (frames_done == '1) ? frames_done : frames_done + 1'b1;

    always_comb begin
        state_nxt     = state;
        line_cnt_nxt  = line_cnt;
        pix_cnt_nxt   = pix_cnt;
        wait_cnt_nxt  = wait_cnt;
        cfg_nxt       = cfg;
        frames_nxt    = frames_done;
        stop_pend_nxt = stop_pend;
        line_err_nxt  = line_err;
        pix_err_nxt   = pix_err;
        tmo_err_nxt   = tmo_err;

        if (hs_rise) begin
            pix_cnt_nxt = GW'(1);
        end else if (hs && pix_cnt != G_MAX) begin
            pix_cnt_nxt = pix_cnt + 1'b1;
        end

        if (err_clr) begin
            line_err_nxt = 1'b0;
            pix_err_nxt  = 1'b0;
            tmo_err_nxt  = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nxt     = S_ARM;
                    cfg_nxt       = frame_cfg;
                    frames_nxt    = '0;
                    line_err_nxt  = 1'b0;
                    pix_err_nxt   = 1'b0;
                    tmo_err_nxt   = 1'b0;
                    stop_pend_nxt = 1'b0;
                    wait_cnt_nxt  = '0;
                end
            end
            S_ARM: begin
                if (fs_rise) begin
                    state_nxt    = S_RUN;
                    line_cnt_nxt = '0;
                end else if (stop) begin
                    state_nxt = S_DONE;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nxt   = S_ERR;
                    tmo_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_nxt = 1'b1;
                end
                if (hs_fall) begin
                    if (pix_cnt != LIE_V) begin
                        pix_err_nxt = 1'b1;
                    end
                    line_cnt_nxt = lines_seen;
                end
                if (fs_fall) begin
                    if (lines_seen != HANG_V) begin
                        line_err_nxt = 1'b1;
                    end
                    frames_nxt = frames_inc;
                    if (stop_pend || stop || (cfg != '0 && frames_inc == cfg)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // stop wins over a coincident fs rise so no partial frame is started
                if (stop) begin
                    state_nxt = S_DONE;
                end else if (fs_rise) begin
                    state_nxt    = S_RUN;
                    line_cnt_nxt = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fs_d        <= 1'b0;
            hs_d        <= 1'b0;
            line_cnt    <= '0;
            pix_cnt     <= '0;
            wait_cnt    <= '0;
            cfg         <= '0;
            stop_pend   <= 1'b0;
            frames_done <= '0;
            line_err    <= 1'b0;
            pix_err     <= 1'b0;
            tmo_err     <= 1'b0;
            gen_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            fs_d        <= fs;
            hs_d        <= hs;
            line_cnt    <= line_cnt_nxt;
            pix_cnt     <= pix_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
            cfg         <= cfg_nxt;
            stop_pend   <= stop_pend_nxt;
            frames_done <= frames_nxt;
            line_err    <= line_err_nxt;
            pix_err     <= pix_err_nxt;
            tmo_err     <= tmo_err_nxt;
            gen_en      <= (state_nxt == S_ARM) || (state_nxt == S_RUN) || (state_nxt == S_GAP);
            busy        <= (state_nxt != S_IDLE);
            done        <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Bench for frame_seq_ctrl: drives a behavioural fs/hs generator and compares the
// controller's status against frame-level expectations.
module tb_frame_seq_ctrl;
    localparam int HN  = 32;
    localparam int LN  = 32;
    localparam int TMO = 64;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst, start, stop, err_clr, fs, hs;
    logic [CW-1:0] frame_cfg;
    logic          gen_en, busy, done, line_err, pix_err, tmo_err;
    logic [CW-1:0] frames_done;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    frame_seq_ctrl #(.HANG_NUM(HN), .LIE_NUM(LN), .ARM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .err_clr(err_clr),
        .frame_cfg(frame_cfg), .fs(fs), .hs(hs), .gen_en(gen_en), .busy(busy),
        .done(done), .frames_done(frames_done), .line_err(line_err),
        .pix_err(pix_err), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctl_kind 1 pulses stop, 2 pulses start (with a new frame_cfg) at the start of ctl_line.
    task automatic send_frame(input int lines, input int bad_line, input int bad_len, input int hb,
                              input bit fast_end, input int ctl_line, input int ctl_kind);
        int len;
        fs = 1'b1;
        tick();
        for (int l = 0; l < lines; l++) begin
            len = (l == bad_line) ? bad_len : LN;
            hs = 1'b1;
            if (l == ctl_line) begin
                if (ctl_kind == 1) stop = 1'b1;
                else begin start = 1'b1; frame_cfg = CW'(7); end
            end
            tick();
            stop = 1'b0;
            start = 1'b0;
            repeat (len - 1) tick();
            hs = 1'b0;
            if (fast_end && l == lines - 1) fs = 1'b0;
            repeat (hb) tick();
        end
        fs = 1'b0;
        tick();
    endtask

    task automatic gap(input int n);
        fs = 1'b0;
        hs = 1'b0;
        repeat (n) tick();
    endtask

    task automatic begin_run(input int cfg);
        frame_cfg = CW'(cfg);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if ({gen_en, busy, done, line_err, pix_err, tmo_err} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {gen_en, busy, done, line_err, pix_err, tmo_err}); end
        checks++; if (frames_done !== '0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_done); end
        rst = 1'b0;
        tick();
        begin_run(0);
        send_frame(HN, -1, LN, 2, 1'b0, -1, 0);
        gap(2);
        fs = 1'b1; tick(); hs = 1'b1; repeat (5) tick();
        checks++; if (frames_done !== CW'(1) || gen_en !== 1'b1) begin errors++; $display("FAIL pre_reset_run: got frames=%0d gen_en=%b want 1 1", frames_done, gen_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({gen_en, busy, done, line_err, pix_err, tmo_err} !== 6'b0) begin errors++; $display("FAIL async_reset_flags: got %b want 000000", {gen_en, busy, done, line_err, pix_err, tmo_err}); end
        checks++; if (frames_done !== '0) begin errors++; $display("FAIL async_reset_frames: got %0d want 0", frames_done); end
        fs = 1'b0; hs = 1'b0;
        tick();
        rst = 1'b0;
        fs = 1'b1; repeat (3) tick(); fs = 1'b0; tick();
        checks++; if (gen_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got gen_en=%b busy=%b want 0 0", gen_en, busy); end
    endtask

    task automatic test_cfg2();
        int d0;
        d0 = done_pulses;
        begin_run(2);
        checks++; if (gen_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cfg2_arm: got gen_en=%b busy=%b want 1 1", gen_en, busy); end
        send_frame(HN, -1, LN, 3, 1'b0, -1, 0);
        checks++; if (frames_done !== CW'(1) || done !== 1'b0 || gen_en !== 1'b1) begin errors++; $display("FAIL cfg2_first: got frames=%0d done=%b gen_en=%b want 1 0 1", frames_done, done, gen_en); end
        gap(3);
        send_frame(HN, -1, LN, 3, 1'b0, -1, 0);
        checks++; if (done !== 1'b1 || gen_en !== 1'b0) begin errors++; $display("FAIL cfg2_done: got done=%b gen_en=%b want 1 0", done, gen_en); end
        checks++; if (frames_done !== CW'(2)) begin errors++; $display("FAIL cfg2_frames: got %0d want 2", frames_done); end
        checks++; if ({line_err, pix_err, tmo_err} !== 3'b0) begin errors++; $display("FAIL cfg2_errs: got %b want 000", {line_err, pix_err, tmo_err}); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || done_pulses - d0 != 1) begin errors++; $display("FAIL cfg2_pulse: got done=%b busy=%b pulses=%0d want 0 0 1", done, busy, done_pulses - d0); end
    endtask

    task automatic test_stop();
        begin_run(0);
        send_frame(HN, -1, LN, 2, 1'b0, -1, 0);
        gap(2);
        send_frame(HN, -1, LN, 2, 1'b0, -1, 0);
        gap(2);
        send_frame(HN, -1, LN, 2, 1'b0, 10, 1);
        checks++; if (done !== 1'b1 || gen_en !== 1'b0) begin errors++; $display("FAIL stop_done: got done=%b gen_en=%b want 1 0", done, gen_en); end
        checks++; if (frames_done !== CW'(3)) begin errors++; $display("FAIL stop_frames: got %0d want 3", frames_done); end
        repeat (4) tick();
        checks++; if (frames_done !== CW'(3) || busy !== 1'b0) begin errors++; $display("FAIL stop_hold: got frames=%0d busy=%b want 3 0", frames_done, busy); end
        // stop in the inter-frame gap, coincident with the next fs rise
        begin_run(0);
        send_frame(HN, -1, LN, 2, 1'b0, -1, 0);
        gap(1);
        stop = 1'b1; fs = 1'b1;
        tick();
        stop = 1'b0; fs = 1'b0;
        checks++; if (done !== 1'b1 || frames_done !== CW'(1)) begin errors++; $display("FAIL gap_stop: got done=%b frames=%0d want 1 1", done, frames_done); end
        tick();
    endtask

    task automatic test_pix_err();
        begin_run(1);
        send_frame(HN, 5, LN - 1, 3, 1'b0, -1, 0);
        checks++; if (pix_err !== 1'b1 || line_err !== 1'b0) begin errors++; $display("FAIL pix_flag: got pix=%b line=%b want 1 0", pix_err, line_err); end
        checks++; if (done !== 1'b1 || frames_done !== CW'(1)) begin errors++; $display("FAIL pix_done: got done=%b frames=%0d want 1 1", done, frames_done); end
        repeat (5) tick();
        checks++; if (pix_err !== 1'b1) begin errors++; $display("FAIL pix_sticky: got %b want 1", pix_err); end
        begin_run(1);
        checks++; if (pix_err !== 1'b0) begin errors++; $display("FAIL pix_clear: got %b want 0", pix_err); end
        send_frame(HN, -1, LN, 3, 1'b0, -1, 0);
        checks++; if (done !== 1'b1 || pix_err !== 1'b0) begin errors++; $display("FAIL pix_clean_run: got done=%b pix=%b want 1 0", done, pix_err); end
        tick();
    endtask

    task automatic test_timeout();
        begin_run(1);
        repeat (TMO - 1) tick();
        checks++; if (tmo_err !== 1'b0 || gen_en !== 1'b1) begin errors++; $display("FAIL tmo_early: got tmo=%b gen_en=%b want 0 1", tmo_err, gen_en); end
        tick();
        checks++; if (tmo_err !== 1'b1 || gen_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_err: got tmo=%b gen_en=%b busy=%b want 1 0 1", tmo_err, gen_en, busy); end
        begin_run(1);
        tick();
        checks++; if (tmo_err !== 1'b1 || busy !== 1'b1 || gen_en !== 1'b0) begin errors++; $display("FAIL err_start: got tmo=%b busy=%b gen_en=%b want 1 1 0", tmo_err, busy, gen_en); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (tmo_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_clr: got tmo=%b busy=%b want 0 0", tmo_err, busy); end
    endtask

    task automatic test_start_rules();
        int d0;
        frame_cfg = CW'(1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || gen_en !== 1'b0) begin errors++; $display("FAIL start_stop: got busy=%b gen_en=%b want 0 0", busy, gen_en); end
        d0 = done_pulses;
        begin_run(1);
        send_frame(HN, -1, LN, 2, 1'b0, 7, 2);
        checks++; if (done !== 1'b1 || frames_done !== CW'(1) || gen_en !== 1'b0) begin errors++; $display("FAIL run_restart: got done=%b frames=%0d gen_en=%b want 1 1 0", done, frames_done, gen_en); end
        tick();
        checks++; if (done_pulses - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL run_restart_pulse: got pulses=%0d busy=%b want 1 0", done_pulses - d0, busy); end
    endtask

    task automatic test_random();
        int cfg, lines, bl, blen, d0;
        bit exp_le, exp_pe, fe;
        for (int run = 0; run < 4; run++) begin
            cfg = int'($urandom_range(1, 3));
            exp_le = 1'b0;
            exp_pe = 1'b0;
            d0 = done_pulses;
            begin_run(cfg);
            for (int f = 0; f < cfg; f++) begin
                lines = HN;
                if ($urandom_range(0, 3) == 0) lines = ($urandom_range(0, 1) == 1) ? HN + 1 : HN - 1;
                bl = -1;
                blen = LN;
                if ($urandom_range(0, 3) == 0) begin
                    bl = int'($urandom_range(0, lines - 1));
                    blen = ($urandom_range(0, 1) == 1) ? LN + int'($urandom_range(1, 2)) : LN - int'($urandom_range(1, 2));
                end
                fe = (f < cfg - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (lines != HN) exp_le = 1'b1;
                if (bl >= 0) exp_pe = 1'b1;
                send_frame(lines, bl, blen, int'($urandom_range(1, 4)), fe, -1, 0);
                if (f < cfg - 1) gap(int'($urandom_range(1, 4)));
            end
            checks++; if (done !== 1'b1 || gen_en !== 1'b0 || frames_done !== CW'(cfg)) begin errors++; $display("FAIL rnd_done run%0d: got done=%b gen_en=%b frames=%0d want 1 0 %0d", run, done, gen_en, frames_done, cfg); end
            checks++; if (line_err !== exp_le || pix_err !== exp_pe) begin errors++; $display("FAIL rnd_errs run%0d: got line=%b pix=%b want %b %b", run, line_err, pix_err, exp_le, exp_pe); end
            tick();
            checks++; if (done_pulses - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL rnd_pulse run%0d: got pulses=%0d busy=%b want 1 0", run, done_pulses - d0, busy); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        err_clr = 1'b0;
        fs = 1'b0;
        hs = 1'b0;
        frame_cfg = '0;
        test_reset();
        test_cfg2();
        test_stop();
        test_pix_err();
        test_timeout();
        test_start_rules();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
